// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    MC_BUSY    = 2'd2,
    REDIR_PEND = 2'd3
  } hz_state_e;

  // Architectural zero register; writes to it never create a dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Per pipeline-register control pair. Stall takes precedence over flush.
  typedef struct packed {
    logic stall;
    logic flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_PASS   = '{stall: 1'b0, flush: 1'b0};
  localparam hz_ctrl_t HZ_HOLD   = '{stall: 1'b1, flush: 1'b0};
  localparam hz_ctrl_t HZ_BUBBLE = '{stall: 1'b0, flush: 1'b1};

  // True when a used source operand matches a real (non-x0) destination.
  function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                   input logic [4:0] rd);
    return use_src & (src == rd) & (rd != REG_X0);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter: sticks at all-ones, clears on reset.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count qualifying cycles until the counter is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_hazard_ctrl_chk.sv
// Property checker for pipe_hazard_ctrl: a pipeline register is never told
// to stall and flush in the same cycle.
module pipe_hazard_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic fd_stall,
  input logic fd_flush,
  input logic de_stall,
  input logic de_flush,
  input logic em_stall,
  input logic em_flush,
  input logic mw_stall,
  input logic mw_flush
);

  a_fd_excl: assert property (@(posedge clk) disable iff (rst) !(fd_stall && fd_flush))
    else $error("FAIL chk_fd_excl stall=1 flush=1 required not both");
  a_de_excl: assert property (@(posedge clk) disable iff (rst) !(de_stall && de_flush))
    else $error("FAIL chk_de_excl stall=1 flush=1 required not both");
  a_em_excl: assert property (@(posedge clk) disable iff (rst) !(em_stall && em_flush))
    else $error("FAIL chk_em_excl stall=1 flush=1 required not both");
  a_mw_excl: assert property (@(posedge clk) disable iff (rst) !(mw_stall && mw_flush))
    else $error("FAIL chk_mw_excl stall=1 flush=1 required not both");

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush for F/D, D/E, E/M, M/W and PC hold.
// Covers load-use interlock, multi-cycle execute, data-memory wait and
// control redirects (held while any stall is active).
// Optional build macro HAZARD_PERF_EN adds three saturating perf counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4
`ifdef HAZARD_PERF_EN
  ,parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic       d_use_rs1,
  input  logic       d_use_rs2,
  input  logic       e_valid,
  input  logic [4:0] e_rd,
  input  logic       e_is_load,
  input  logic       e_mc_start,
  input  logic       redirect,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_hold,
  output logic       fd_stall,
  output logic       fd_flush,
  output logic       de_stall,
  output logic       de_flush,
  output logic       em_stall,
  output logic       em_flush,
  output logic       mw_stall,
  output logic       mw_flush,
  output logic       redirect_go
`ifdef HAZARD_PERF_EN
  ,output logic [CNT_W-1:0] perf_stall_cyc
  ,output logic [CNT_W-1:0] perf_flush_evt
  ,output logic [CNT_W-1:0] perf_redir_pend
`endif
);

  // Remaining stall cycles after the start cycle; zero marks the advance cycle.
  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 1);

  hz_state_e  state_r;
  hz_state_e  state_nxt_s;
  logic [3:0] mc_cnt_r;
  logic       mc_act_r;

  logic       mem_wait_s;
  logic       load_use_s;
  logic       mc_load_s;
  logic       mc_hold_s;
  logic       stall_any_s;
  logic       pend_s;
  logic       redir_req_s;
  logic       redir_go_s;

  logic       pc_hold_s;
  logic       redirect_go_s;
  hz_ctrl_t   fd_s;
  hz_ctrl_t   de_s;
  hz_ctrl_t   em_s;
  hz_ctrl_t   mw_s;

  assign mem_wait_s  = dmem_req & ~dmem_ready;
  assign load_use_s  = e_valid & e_is_load &
                       (src_hit(d_use_rs1, d_rs1, e_rd) | src_hit(d_use_rs2, d_rs2, e_rd));
  // A new multi-cycle op is accepted only when none is active and memory is not waiting.
  assign mc_load_s   = ~mc_act_r & e_mc_start & ~mem_wait_s;
  // The start cycle stalls too, so the op holds E for MC_LAT stall cycles in total.
  assign mc_hold_s   = mc_act_r ? (mc_cnt_r != 4'd0) : e_mc_start;
  assign stall_any_s = mem_wait_s | mc_hold_s;
  assign pend_s      = (state_r == REDIR_PEND);
  // A pending redirect absorbs any further pulse until it is released.
  assign redir_req_s = redirect | pend_s;
  assign redir_go_s  = redir_req_s & ~stall_any_s;

  // Next-state selection; a held redirect dominates the reported state.
  always_comb begin
    state_nxt_s = RUN;
    if (stall_any_s && redir_req_s) begin
      state_nxt_s = REDIR_PEND;
    end else if (mc_load_s || (mc_act_r && (mem_wait_s || (mc_cnt_r != 4'd0)))) begin
      state_nxt_s = MC_BUSY;
    end else if (mem_wait_s) begin
      state_nxt_s = MEM_WAIT;
    end else begin
      state_nxt_s = RUN;
    end
  end

  // State and multi-cycle countdown; the count freezes while memory is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RUN;
      mc_cnt_r <= 4'd0;
      mc_act_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (mc_load_s) begin
        mc_act_r <= 1'b1;
        mc_cnt_r <= MC_INIT;
      end else if (mc_act_r && !mem_wait_s) begin
        if (mc_cnt_r == 4'd0) begin
          mc_act_r <= 1'b0;
        end else begin
          mc_cnt_r <= mc_cnt_r - 4'd1;
        end
      end
    end
  end

  // Priority decode of stall/flush: reset, memory wait, multi-cycle, redirect, load-use.
  always_comb begin
    pc_hold_s     = 1'b0;
    redirect_go_s = 1'b0;
    fd_s          = HZ_PASS;
    de_s          = HZ_PASS;
    em_s          = HZ_PASS;
    mw_s          = HZ_PASS;
    if (rst) begin
      pc_hold_s = 1'b1;
      fd_s      = HZ_BUBBLE;
      de_s      = HZ_BUBBLE;
      em_s      = HZ_BUBBLE;
      mw_s      = HZ_BUBBLE;
    end else if (mem_wait_s) begin
      pc_hold_s = 1'b1;
      fd_s      = HZ_HOLD;
      de_s      = HZ_HOLD;
      em_s      = HZ_HOLD;
      mw_s      = HZ_BUBBLE;
    end else if (mc_hold_s) begin
      pc_hold_s = 1'b1;
      fd_s      = HZ_HOLD;
      de_s      = HZ_HOLD;
      em_s      = HZ_BUBBLE;
    end else if (redir_go_s) begin
      // Redirect wins over load-use; the D/E bubble kills the dependent instr.
      redirect_go_s = 1'b1;
      fd_s          = HZ_BUBBLE;
      de_s          = HZ_BUBBLE;
    end else if (load_use_s) begin
      pc_hold_s = 1'b1;
      fd_s      = HZ_HOLD;
      de_s      = HZ_BUBBLE;
    end else begin
      pc_hold_s     = 1'b0;
      redirect_go_s = 1'b0;
    end
  end

  assign pc_hold     = pc_hold_s;
  assign redirect_go = redirect_go_s;
  assign fd_stall    = fd_s.stall;
  assign fd_flush    = fd_s.flush;
  assign de_stall    = de_s.stall;
  assign de_flush    = de_s.flush;
  assign em_stall    = em_s.stall;
  assign em_flush    = em_s.flush;
  assign mw_stall    = mw_s.stall;
  assign mw_flush    = mw_s.flush;

`ifdef HAZARD_PERF_EN
  logic pend_entry_s;

  assign pend_entry_s = (state_nxt_s == REDIR_PEND) & ~pend_s;

  hazard_perf_cnt #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_hold_s),
    .count (perf_stall_cyc)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_go_s),
    .count (perf_flush_evt)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_cnt_pend (
    .clk   (clk),
    .rst   (rst),
    .inc   (pend_entry_s),
    .count (perf_redir_pend)
  );
`endif

endmodule
